// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared types, opcodes and constants for the instruction encoder
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_HALT = 3'd6
    } instr_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    typedef logic [6:0]  opcode_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    localparam word_t   HALT_WORD = 32'hFFFF_FFFF;
    localparam opcode_t OP_RTYPE  = 7'h33;
    localparam opcode_t OP_ITYPE  = 7'h13;
    localparam opcode_t OP_LOAD   = 7'h03;
    localparam opcode_t OP_STORE  = 7'h23;
    localparam opcode_t OP_BRANCH = 7'h63;
    localparam opcode_t OP_LUI    = 7'h37;
    localparam opcode_t OP_JAL    = 7'h6F;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational RV32I field packer with immediate range check
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  instr_fmt_t  fmt,
    input  opcode_t     opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  regbits_t    rs1,
    input  regbits_t    rs2,
    input  regbits_t    rd,
    input  word_t       imm,
    output word_t       word,
    output logic        range_err
);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                word      = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !in_range(imm, -32'sd2048, 32'sd2047);
            end
            FMT_S: begin
                word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !in_range(imm, -32'sd2048, 32'sd2047);
            end
            FMT_B: begin
                word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !in_range(imm, -32'sd4096, 32'sd4094) || imm[0];
            end
            FMT_U: begin
                word      = {imm[31:12], rd, opcode};
                range_err = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !in_range(imm, -32'sd1048576, 32'sd1048575) || imm[0];
            end
            FMT_HALT: begin
                word = HALT_WORD;
            end
            default: begin
                word = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes field bundles into RV32I words and writes them to instruction memory
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter word_t BASE_ADDR = 32'h0000_0000,
    parameter int    MAX_WORDS = 1024
)(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic        req_valid,
    output logic        req_ready,
    input  instr_fmt_t  fmt,
    input  opcode_t     opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  regbits_t    rs1,
    input  regbits_t    rs2,
    input  regbits_t    rd,
    input  word_t       imm,
    output logic        mem_wen,
    output word_t       mem_addr,
    output word_t       mem_wdata,
    input  logic        mem_wait,
    output logic [10:0] words,
    output logic        done,
    output logic        enc_err
);

    localparam logic [10:0] MAX_W = 11'(MAX_WORDS);

    enc_state_t  state_q, state_d;
    logic        halt_q;
    word_t       pack_word;
    logic        pack_err;
    logic        accept, wr_done, restart, hit_max;
    logic [10:0] words_inc;

    instr_field_pack u_pack (
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .word      (pack_word),
        .range_err (pack_err)
    );

    // Strobes decode straight from state so reset drops mem_wen without waiting for a clock.
    assign req_ready = (state_q == ST_RUN);
    assign mem_wen   = (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);

    assign accept    = req_ready && req_valid;
    assign wr_done   = mem_wen && !mem_wait;
    assign restart   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign words_inc = words + 11'd1;
    assign hit_max   = (words_inc >= MAX_W);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_RUN;
            ST_RUN:   if (req_valid) state_d = ST_WRITE;
            ST_WRITE: if (!mem_wait) state_d = (halt_q || hit_max) ? ST_DONE : ST_RUN;
            ST_DONE:  if (start)     state_d = ST_RUN;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            halt_q    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            words     <= '0;
            enc_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                mem_addr <= BASE_ADDR;
                words    <= '0;
                enc_err  <= 1'b0;
            end
            if (accept) begin
                mem_wdata <= pack_word;
                halt_q    <= (fmt == FMT_HALT);
                if (pack_err) enc_err <= 1'b1;
            end
            if (wr_done) begin
                mem_addr <= mem_addr + 32'd4;
                words    <= (words >= MAX_W) ? words : words_inc;
                // Filling the last slot with a real instruction leaves no room for HALT.
                if (hit_max && !halt_q) enc_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam word_t BASE = 32'h0000_0100;
    localparam int    MAXW = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    instr_fmt_t  fmt = FMT_R;
    opcode_t     opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    regbits_t    rs1 = '0;
    regbits_t    rs2 = '0;
    regbits_t    rd = '0;
    word_t       imm = '0;
    logic        mem_wen;
    word_t       mem_addr;
    word_t       mem_wdata;
    logic        mem_wait = 1'b0;
    logic [10:0] words;
    logic        done;
    logic        enc_err;

    int total = 0;
    int bad = 0;

    instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wait(mem_wait),
        .words(words), .done(done), .enc_err(enc_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input instr_fmt_t f, input opcode_t op, input logic [2:0] f3,
                         input logic [6:0] f7, input regbits_t s1, input regbits_t s2,
                         input regbits_t d, input word_t im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rs1 = s1; rs2 = s2; rd = d; imm = im;
    endtask

    task automatic issue(input instr_fmt_t f, input opcode_t op, input logic [2:0] f3,
                         input logic [6:0] f7, input regbits_t s1, input regbits_t s2,
                         input regbits_t d, input word_t im);
        int n;
        drive(f, op, f3, f7, s1, s2, d, im);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL issue_timeout req_ready=%0b required=1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic issue_halt();
        issue(FMT_HALT, OP_ITYPE, 3'd5, 7'h20, 5'd3, 5'd4, 5'd5, 32'h123);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        tick();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL rst_mem_wen got=%0b exp=0", mem_wen); end
        total++; if (mem_addr !== BASE) begin bad++; $display("FAIL rst_mem_addr got=%h exp=%h", mem_addr, BASE); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        total++; if (words !== 11'd0) begin bad++; $display("FAIL rst_words got=%0d exp=0", words); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
        total++; if (enc_err !== 1'b0) begin bad++; $display("FAIL rst_enc_err got=%0b exp=0", enc_err); end
        drive(FMT_I, OP_ITYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        req_valid = 1'b1;
        repeat (3) tick();
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL idle_no_accept mem_wen got=%0b exp=0", mem_wen); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL idle_req_ready got=%0b exp=0", req_ready); end
        req_valid = 1'b0;
    endtask

    task automatic test_addi();
        pulse_start();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL run_req_ready got=%0b exp=1", req_ready); end
        issue(FMT_I, OP_ITYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        total++; if (mem_wen !== 1'b1) begin bad++; $display("FAIL addi_wen got=%0b exp=1", mem_wen); end
        total++; if (mem_wdata !== 32'h0050_0093) begin bad++; $display("FAIL addi_word got=%h exp=00500093", mem_wdata); end
        total++; if (mem_addr !== BASE) begin bad++; $display("FAIL addi_addr got=%h exp=%h", mem_addr, BASE); end
        total++; if (enc_err !== 1'b0) begin bad++; $display("FAIL addi_err got=%0b exp=0", enc_err); end
        tick();
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL addi_wen_drop got=%0b exp=0", mem_wen); end
        total++; if (words !== 11'd1) begin bad++; $display("FAIL addi_words got=%0d exp=1", words); end
        issue_halt();
        total++; if (mem_wdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL halt1_word got=%h exp=ffffffff", mem_wdata); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL halt1_done got=%0b exp=1", done); end
    endtask

    task automatic test_sequence();
        pulse_start();
        total++; if (mem_addr !== BASE) begin bad++; $display("FAIL seq_restart_addr got=%h exp=%h", mem_addr, BASE); end
        total++; if (words !== 11'd0) begin bad++; $display("FAIL seq_restart_words got=%0d exp=0", words); end
        issue(FMT_R, OP_RTYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        total++; if (mem_wdata !== 32'h0020_81B3) begin bad++; $display("FAIL add_word got=%h exp=002081b3", mem_wdata); end
        total++; if (mem_addr !== BASE) begin bad++; $display("FAIL add_addr got=%h exp=%h", mem_addr, BASE); end
        tick();
        issue(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        total++; if (mem_wdata !== 32'h0020_A423) begin bad++; $display("FAIL sw_word got=%h exp=0020a423", mem_wdata); end
        total++; if (mem_addr !== BASE + 32'd4) begin bad++; $display("FAIL sw_addr got=%h exp=%h", mem_addr, BASE + 32'd4); end
        tick();
        total++; if (words !== 11'd2) begin bad++; $display("FAIL seq_words got=%0d exp=2", words); end
        issue_halt();
        total++; if (mem_wdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL halt_word got=%h exp=ffffffff", mem_wdata); end
        total++; if (mem_addr !== BASE + 32'd8) begin bad++; $display("FAIL halt_addr got=%h exp=%h", mem_addr, BASE + 32'd8); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_done got=%0b exp=1", done); end
        total++; if (words !== 11'd3) begin bad++; $display("FAIL halt_words got=%0d exp=3", words); end
        drive(FMT_I, OP_ITYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        req_valid = 1'b1;
        repeat (3) tick();
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL done_no_accept got=%0b exp=0", mem_wen); end
        total++; if (words !== 11'd3) begin bad++; $display("FAIL done_words got=%0d exp=3", words); end
        total++; if (mem_addr !== BASE + 32'd12) begin bad++; $display("FAIL done_addr got=%h exp=%h", mem_addr, BASE + 32'd12); end
        req_valid = 1'b0;
    endtask

    task automatic test_encodings();
        pulse_start();
        issue(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        total++; if (mem_wdata !== 32'h0020_8463) begin bad++; $display("FAIL beq_word got=%h exp=00208463", mem_wdata); end
        total++; if (enc_err !== 1'b0) begin bad++; $display("FAIL beq_err got=%0b exp=0", enc_err); end
        tick();
        issue(FMT_U, OP_LUI, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd5, 32'h1234_5000);
        total++; if (mem_wdata !== 32'h1234_52B7) begin bad++; $display("FAIL lui_word got=%h exp=123452b7", mem_wdata); end
        tick();
        issue(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800);
        total++; if (mem_wdata !== 32'h0010_00EF) begin bad++; $display("FAIL jal_word got=%h exp=001000ef", mem_wdata); end
        tick();
        issue_halt();
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL lastslot_halt_done got=%0b exp=1", done); end
        total++; if (enc_err !== 1'b0) begin bad++; $display("FAIL lastslot_halt_err got=%0b exp=0", enc_err); end
        total++; if (words !== 11'd4) begin bad++; $display("FAIL lastslot_words got=%0d exp=4", words); end
    endtask

    task automatic test_range();
        pulse_start();
        issue(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd7);
        total++; if (enc_err !== 1'b1) begin bad++; $display("FAIL beq7_err got=%0b exp=1", enc_err); end
        total++; if (mem_wdata !== 32'h0020_8363) begin bad++; $display("FAIL beq7_word got=%h exp=00208363", mem_wdata); end
        tick();
        pulse_start();
        total++; if (enc_err !== 1'b1) begin bad++; $display("FAIL start_in_run_err got=%0b exp=1", enc_err); end
        total++; if (mem_addr !== BASE + 32'd4) begin bad++; $display("FAIL start_in_run_addr got=%h exp=%h", mem_addr, BASE + 32'd4); end
        issue(FMT_I, OP_ITYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800);
        total++; if (mem_wdata !== 32'h8000_0093) begin bad++; $display("FAIL addi2048_word got=%h exp=80000093", mem_wdata); end
        tick();
        issue_halt();
        tick();
    endtask

    task automatic test_wait();
        pulse_start();
        total++; if (enc_err !== 1'b0) begin bad++; $display("FAIL start_clears_err got=%0b exp=0", enc_err); end
        mem_wait = 1'b1;
        issue(FMT_I, OP_ITYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem_wen !== 1'b1 || mem_addr !== BASE || mem_wdata !== 32'h0050_0093 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold cyc=%0d got wen=%0b addr=%h data=%h rdy=%0b exp wen=1 addr=%h data=00500093 rdy=0",
                         i, mem_wen, mem_addr, mem_wdata, req_ready, BASE);
            end
            if (i == 3) mem_wait = 1'b0;
            tick();
        end
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL wait_release_wen got=%0b exp=0", mem_wen); end
        total++; if (words !== 11'd1) begin bad++; $display("FAIL wait_words got=%0d exp=1", words); end
        total++; if (mem_addr !== BASE + 32'd4) begin bad++; $display("FAIL wait_addr got=%h exp=%h", mem_addr, BASE + 32'd4); end
        issue_halt();
        tick();
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            issue(FMT_I, OP_ITYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, k);
            tick();
            if (k == 2) begin
                total++;
                if (done !== 1'b0 || enc_err !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_early got done=%0b err=%0b exp done=0 err=0", done, enc_err);
                end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%0b exp=1", done); end
        total++; if (enc_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0b exp=1", enc_err); end
        total++; if (words !== 11'd4) begin bad++; $display("FAIL ovf_words got=%0d exp=4", words); end
        total++; if (mem_addr !== BASE + 32'd16) begin bad++; $display("FAIL ovf_addr got=%h exp=%h", mem_addr, BASE + 32'd16); end
        drive(FMT_I, OP_ITYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd9);
        req_valid = 1'b1;
        repeat (3) tick();
        total++; if (mem_wen !== 1'b0 || words !== 11'd4) begin bad++; $display("FAIL ovf_fifth got wen=%0b words=%0d exp wen=0 words=4", mem_wen, words); end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        pulse_start();
        mem_wait = 1'b1;
        issue(FMT_R, OP_RTYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        total++; if (mem_wen !== 1'b1) begin bad++; $display("FAIL mid_wen_before got=%0b exp=1", mem_wen); end
        #2 nRST = 1'b0;
        #1;
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL mid_rst_wen got=%0b exp=0", mem_wen); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL mid_rst_wdata got=%h exp=0", mem_wdata); end
        total++; if (mem_addr !== BASE || words !== 11'd0) begin bad++; $display("FAIL mid_rst_addr_words got addr=%h words=%0d exp addr=%h words=0", mem_addr, words, BASE); end
        total++; if (req_ready !== 1'b0 || done !== 1'b0 || enc_err !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got rdy=%0b done=%0b err=%0b exp 0 0 0", req_ready, done, enc_err); end
        mem_wait = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        total++; if (mem_wen !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL post_rst_idle got wen=%0b rdy=%0b exp 0 0", mem_wen, req_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sequence();
        test_encodings();
        test_range();
        test_wait();
        test_overflow();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
